chacha_stream_xor: RTL
======================

# chacha_stream_xor

Payload-side companion to the ChaCha20-Poly1305 core. It requests 512-bit keystream blocks over the core's `ks_req`/`ks_valid` interface and splits each block into four 128-bit lanes. Each lane is XORed with an incoming payload beat. The result goes out as a cipher/plain output stream, and the ciphertext is forked into the core's `pld_*` MAC port, so one block drives both encryption/decryption and authentication of the payload.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a message and aborts any message in progress.
- `dir` in 1: direction, sampled on `start`. 0 = encrypt, 1 = decrypt.
- `ks_req` out 1: one-cycle keystream request pulse to the core.
- `ks_valid` in 1: keystream block valid.
- `ks_data` in 512: keystream block; lane i = `ks_data[128*i +: 128]`.
- `in_valid` / `in_ready` in / out 1: input payload handshake.
- `in_data` in 128: input payload beat; byte j = bits `[8j+7:8j]`.
- `in_keep` in 16: byte enables for `in_data`.
- `in_last` in 1: marks the final beat of the message.
- `out_valid` / `out_ready` out / in 1: result handshake.
- `out_data` out 128, `out_keep` out 16, `out_last` out 1: result beat.
- `pld_valid` / `pld_ready` out / in 1: ciphertext handshake to the core MAC port.
- `pld_data` out 128, `pld_keep` out 16: ciphertext beat to the core.
- `done` out 1: one-cycle pulse when the last beat has been retired.

## Operation
- FSM states: IDLE, REQ, WAIT, RUN, FLUSH.
- IDLE:
  - `start` → REQ.
  - Input beats are not accepted.
- REQ:
  - `ks_req`=1 for exactly this cycle.
  - Next state is WAIT.
- WAIT:
  - On `ks_valid`=1, capture `ks_data` into the keystream buffer, set lane=0, buf_valid=1, and go to RUN.
  - `ks_valid` is ignored in every other state.
- RUN:
  - `in_ready` = buf_valid AND (output register empty OR retiring this cycle).
  - On an input handshake, the output register loads:
    - `out_data` = (`in_data` XOR lane) with bytes where keep=0 forced to 0.
    - `out_keep` = `in_keep`; `out_last` = `in_last`.
    - `pld_data`: the masked `out_data` when `dir`=0; the masked `in_data` when `dir`=1.
    - `pld_keep` = `in_keep`.
  - lane increments after each accepted beat. After lane 3, buf_valid clears.
  - Accepted beat with `in_last` → FLUSH.
  - Else, buf_valid cleared → REQ.
- FLUSH:
  - Waits for the output register to retire, then pulses `done` and returns to IDLE.
  - Unused keystream lanes are discarded.
- Fork rule:
  - The output register presents `out_valid` and `pld_valid` independently. Each port has a "taken" flag that is set on its handshake.
  - The register retires when both ports have been taken, counting handshakes in the current cycle.
  - A valid on a port stays high until that port's handshake; after it is taken, that valid drops.
- `in_keep` must be contiguous from bit 0. It may be partial only on the `in_last` beat; other patterns give undefined results.
- `start` in any state has priority:
  - Clears the buffer, output register and taken flags.
  - Re-samples `dir`.
  - Goes to REQ.
  - No `done` is emitted for the aborted message.

## Timing
- Reset values: `ks_req`, `in_ready`, `out_valid`, `pld_valid`, `out_last`, `done` = 0. `out_data`, `pld_data`, `out_keep`, `pld_keep` = 0. State = IDLE, lane = 0.
- `start` at cycle T → `ks_req`=1 at T+1.
- `ks_valid` at cycle K → `in_ready` can first be 1 at K+1.
- Input handshake at cycle T → `out_valid`/`pld_valid` = 1 at T+1, registered.
- Sustained throughput: 1 beat/cycle within a keystream block when both sinks are ready.
- Fourth beat accepted at T → `ks_req` at T+1; the next beat is accepted no earlier than (`ks_valid` cycle)+1.
- Final beat retired at R → `done`=1 at R+1, state IDLE at R+1.
- `start` and a handshake in the same cycle: `start` wins and the beat is dropped.

## Test plan
- Encrypt, 4 full beats (keep=FFFF), `ks_data` = lanes A/B/C/D, data 0 → `out_data` = A,B,C,D in order; `pld_data` identical; exactly one `ks_req`; `done` one cycle after the last retire.
- Encrypt, 5 beats → two `ks_req` pulses; beat 5 XORed with lane 0 of the second block; lanes 1-3 of the second block unused; `done` once.
- Partial last beat, keep=00FF, `in_data`=all FF, lane=all 00 → `out_data` = 0x…00FFFFFFFFFFFFFFFF (upper 8 bytes 0); `out_keep`=00FF; `out_last`=1.
- Fork backpressure: `out_ready`=0 for 5 cycles while `pld_ready`=1 → `pld_valid` drops after 1 cycle; `in_ready`=0 until `out_ready` rises; no beat is duplicated or lost.
- Decrypt (`dir`=1), ciphertext C in → `out_data` = C XOR lane; `pld_data` = C.
- `rst` asserted mid-RUN, and separately `start` mid-message → all outputs reset/cleared; no `done` for the aborted message; the next message completes correctly with a fresh `ks_req`.

Source files
------------

// File: rtl/chacha_stream_xor.sv
// Keystream XOR stage for the ChaCha20-Poly1305 core: XORs payload beats with
// 128-bit lanes of a 512-bit keystream block and forks ciphertext to the MAC port.
module chacha_stream_xor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir,
  output logic         ks_req,
  input  logic         ks_valid,
  input  logic [511:0] ks_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [15:0]  in_keep,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [15:0]  out_keep,
  output logic         out_last,
  output logic         pld_valid,
  input  logic         pld_ready,
  output logic [127:0] pld_data,
  output logic [15:0]  pld_keep,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RUN, FLUSH} state_t;

  state_t       state, next;
  logic [511:0] ks_buf;
  logic [1:0]   lane;
  logic         buf_valid, dir_r;
  logic         vld_p1, out_taken, pld_taken;
  logic         out_hs, pld_hs, retire, in_hs, drained;
  logic [127:0] mask_p0, lane_p0, xor_p0, pld_p0;

  function automatic logic [127:0] byte_mask(input logic [15:0] keep);
    logic [127:0] m;
    m = '0;
    for (int j = 0; j < 16; j++) m[8*j +: 8] = {8{keep[j]}};
    return m;
  endfunction

  // Fork: each port drops its valid once taken; the register retires when both are taken.
  assign out_valid = vld_p1 & ~out_taken;
  assign pld_valid = vld_p1 & ~pld_taken;
  assign out_hs    = out_valid & out_ready;
  assign pld_hs    = pld_valid & pld_ready;
  assign retire    = vld_p1 & (out_taken | out_hs) & (pld_taken | pld_hs);
  assign drained   = ~vld_p1 | retire;
  assign in_ready  = (state == RUN) & buf_valid & drained;
  assign in_hs     = in_valid & in_ready & ~start;
  assign ks_req    = (state == REQ);

  // Stage p0: lane select, XOR and byte masking
  assign mask_p0 = byte_mask(in_keep);
  assign lane_p0 = ks_buf[128*lane +: 128];
  assign xor_p0  = (in_data ^ lane_p0) & mask_p0;
  assign pld_p0  = dir_r ? (in_data & mask_p0) : xor_p0;

  always_comb begin
    next = state;
    if (start) begin
      next = REQ;
    end else begin
      case (state)
        IDLE:    next = IDLE;
        REQ:     next = WAIT;
        WAIT:    if (ks_valid) next = RUN;
        RUN:     if (in_hs) begin
                   if (in_last)          next = FLUSH;
                   else if (lane == 2'd3) next = REQ;
                 end
        FLUSH:   if (drained) next = IDLE;
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_ff @(posedge clk) begin
    if (state == WAIT && ks_valid && !start) ks_buf <= ks_data;
  end

  // Stage p1: output register shared by the result and MAC ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_r     <= 1'b0;
      lane      <= 2'd0;
      buf_valid <= 1'b0;
      vld_p1    <= 1'b0;
      out_taken <= 1'b0;
      pld_taken <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      pld_data  <= '0;
      pld_keep  <= '0;
      done      <= 1'b0;
    end else if (start) begin
      dir_r     <= dir;
      lane      <= 2'd0;
      buf_valid <= 1'b0;
      vld_p1    <= 1'b0;
      out_taken <= 1'b0;
      pld_taken <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      pld_data  <= '0;
      pld_keep  <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == FLUSH) & drained;
      if (state == WAIT && ks_valid) begin
        lane      <= 2'd0;
        buf_valid <= 1'b1;
      end
      if (in_hs) begin
        lane      <= lane + 2'd1;
        buf_valid <= (lane != 2'd3);
        vld_p1    <= 1'b1;
        out_taken <= 1'b0;
        pld_taken <= 1'b0;
        out_data  <= xor_p0;
        out_keep  <= in_keep;
        out_last  <= in_last;
        pld_data  <= pld_p0;
        pld_keep  <= in_keep;
      end else if (retire) begin
        vld_p1    <= 1'b0;
        out_taken <= 1'b0;
        pld_taken <= 1'b0;
      end else begin
        out_taken <= out_taken | out_hs;
        pld_taken <= pld_taken | pld_hs;
      end
    end
  end

endmodule
